// File: rtl/md_unit_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_controller_if
// Description : Bundle between the E-stage controller / hazard logic and the
//               multiply/divide unit. The master drives the MD request and the
//               D-stage hint. The slave (the unit) returns Busy, MDStall, HI
//               and LO.
// Revision    : 1.0 - initial release
// ============================================================================
interface md_unit_controller_if;
    logic        MDStart;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        DIsMD;
    logic        Busy;
    logic        MDStall;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output MDStart, MDOp, A, B, DIsMD,
        input  Busy, MDStall, HI, LO
    );

    modport slave (
        input  MDStart, MDOp, A, B, DIsMD,
        output Busy, MDStall, HI, LO
    );
endinterface
`default_nettype wire

// File: rtl/md_unit_controller.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_controller
// Description : Multi-cycle multiply/divide sequencer with HI/LO ownership and
//               D-stage stall generation. Define MD_MADD_EN to enable the
//               madd/msub accumulate operations (MDOp 6/7).
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit_controller #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire                  clk,
    input  wire                  reset,
    md_unit_controller_if.slave  md
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] pend_q, pend_d;
    logic        pend_wr_q, pend_wr_d;

    logic        w_is_mul, w_is_div, w_is_mac, w_launch_op, w_busy;
    logic        w_b_zero;
    logic [63:0] w_prod_s, w_prod_u, w_result;
    logic [31:0] w_abs_a, w_abs_b, w_div_s, w_div_u;
    logic [31:0] w_quo_mag, w_rem_mag, w_quo_s, w_rem_s, w_quo_u, w_rem_u;

    assign w_is_mul = (md.MDOp == 3'd0) | (md.MDOp == 3'd1);
    assign w_is_div = (md.MDOp == 3'd2) | (md.MDOp == 3'd3);
`ifdef MD_MADD_EN
    assign w_is_mac = (md.MDOp == 3'd6) | (md.MDOp == 3'd7);
`else
    assign w_is_mac = 1'b0;
`endif
    assign w_launch_op = w_is_mul | w_is_div | w_is_mac;

    // Low 64 bits of the extended products are exactly the 32x32 results.
    assign w_prod_s = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
    assign w_prod_u = {32'd0, md.A} * {32'd0, md.B};

    // Signed divide on magnitudes, then fix signs: quotient truncates toward
    // zero, remainder follows the dividend. 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 with no special casing.
    assign w_b_zero  = (md.B == 32'd0);
    assign w_abs_a   = md.A[31] ? (~md.A + 32'd1) : md.A;
    assign w_abs_b   = md.B[31] ? (~md.B + 32'd1) : md.B;
    assign w_div_s   = w_b_zero ? 32'd1 : w_abs_b;
    assign w_div_u   = w_b_zero ? 32'd1 : md.B;
    assign w_quo_mag = w_abs_a / w_div_s;
    assign w_rem_mag = w_abs_a % w_div_s;
    assign w_quo_s   = (md.A[31] ^ md.B[31]) ? (~w_quo_mag + 32'd1) : w_quo_mag;
    assign w_rem_s   = md.A[31] ? (~w_rem_mag + 32'd1) : w_rem_mag;
    assign w_quo_u   = md.A / w_div_u;
    assign w_rem_u   = md.A % w_div_u;

    // Result that will be committed to {HI,LO} at the end of the busy period.
    always_comb begin
        w_result = {hi_q, lo_q};
        case (md.MDOp)
            3'd0:    w_result = w_prod_s;
            3'd1:    w_result = w_prod_u;
            3'd2:    w_result = {w_rem_s, w_quo_s};
            3'd3:    w_result = {w_rem_u, w_quo_u};
`ifdef MD_MADD_EN
            3'd6:    w_result = {hi_q, lo_q} + w_prod_s;
            3'd7:    w_result = {hi_q, lo_q} - w_prod_s;
`endif
            default: w_result = {hi_q, lo_q};
        endcase
    end

    // Next-state: launch / mthi / mtlo from IDLE, count down and commit in BUSY.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            S_IDLE: begin
                if (md.MDStart) begin
                    if (w_launch_op) begin
                        state_d   = S_BUSY;
                        cnt_d     = w_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        pend_d    = w_result;
                        pend_wr_d = ~(w_is_div & w_b_zero);
                    end else if (md.MDOp == 3'd4) begin
                        hi_d = md.A;
                    end else if (md.MDOp == 3'd5) begin
                        lo_d = md.A;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                    if (pend_wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_q    <= 64'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign w_busy     = (state_q == S_BUSY);
    assign md.Busy    = w_busy;
    assign md.MDStall = md.DIsMD & (w_busy | (md.MDStart & w_launch_op));
    assign md.HI      = hi_q;
    assign md.LO      = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_unit_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit_controller
// Description : Randomized scoreboard bench for md_unit_controller. Stimulus
//               pushes expected HI/LO and busy length; a monitor pops on each
//               busy-to-idle transition and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit_controller;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [31:0] m_hi, m_lo;

    md_unit_controller_if u_if ();

    md_unit_controller #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (u_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: what {HI,LO} should hold after op, given current model state.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output bit launch, output int n, output logic [63:0] res);
        longint ps;
        longint unsigned pu;
        int sq, sr;
        ps = longint'(int'(a)) * longint'(int'(b));
        pu = longint'({32'd0, a}) * longint'({32'd0, b});
        launch = 1'b0;
        n = 0;
        res = {m_hi, m_lo};
        case (op)
            3'd0: begin launch = 1; n = MULT_N; res = ps; end
            3'd1: begin launch = 1; n = MULT_N; res = pu; end
            3'd2: begin
                launch = 1; n = DIV_N;
                if (b == 0) res = {m_hi, m_lo};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
                else begin
                    sq = int'(a) / int'(b);
                    sr = int'(a) % int'(b);
                    res = {sr, sq};
                end
            end
            3'd3: begin
                launch = 1; n = DIV_N;
                if (b != 0) res = {a % b, a / b};
            end
            3'd4: res = {a, m_lo};
            3'd5: res = {m_hi, a};
`ifdef MD_MADD_EN
            3'd6: begin launch = 1; n = MULT_N; res = {m_hi, m_lo} + ps; end
            3'd7: begin launch = 1; n = MULT_N; res = {m_hi, m_lo} - ps; end
`endif
            default: res = {m_hi, m_lo};
        endcase
    endtask

    // Issue one operation and wait (bounded) for it to complete.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit launch;
        int n;
        int t;
        logic [63:0] res;
        exp_t e;
        @(posedge clk); #1;
        u_if.MDStart = 1'b1; u_if.MDOp = op; u_if.A = a; u_if.B = b;
        model(op, a, b, launch, n, res);
        m_hi = res[63:32];
        m_lo = res[31:0];
        if (launch) begin
            e.hi = m_hi; e.lo = m_lo; e.n = n;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        u_if.MDStart = 1'b0;
        if (launch) begin
            t = 0;
            while (sb.size() != 0 && t < 40) begin
                @(negedge clk); #1;
                t++;
            end
            if (sb.size() != 0) begin
                chk("completion_timeout", 64'(sb.size()), 64'd0);
                sb.delete();
            end
        end else begin
            @(negedge clk);
            chk($sformatf("imm_op%0d_hilo", op), {u_if.HI, u_if.LO}, {m_hi, m_lo});
            chk($sformatf("imm_op%0d_busy", op), 64'(u_if.Busy), 64'd0);
        end
    endtask

    // Monitor: counts busy cycles and checks each result when Busy drops.
    int  busy_cnt = 0;
    bit  prev_busy = 0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy_cnt  = 0;
            prev_busy = 0;
        end else begin
            if (u_if.Busy) begin
                busy_cnt++;
            end else if (prev_busy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("result_hi", 64'(u_if.HI), 64'(e.hi));
                    chk("result_lo", 64'(u_if.LO), 64'(e.lo));
                    chk("busy_cycles", 64'(busy_cnt), 64'(e.n));
                end
                busy_cnt = 0;
            end
            prev_busy = u_if.Busy;
        end
    end

    initial begin
        exp_t e;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        reset = 1'b1;
        u_if.MDStart = 1'b0; u_if.MDOp = 3'd0; u_if.A = 32'd0; u_if.B = 32'd0;
        u_if.DIsMD = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_hi", 64'(u_if.HI), 64'd0);
        chk("reset_lo", 64'(u_if.LO), 64'd0);
        chk("reset_busy", 64'(u_if.Busy), 64'd0);
        chk("reset_stall", 64'(u_if.MDStall), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        u_if.DIsMD = 1'b0;

        // Directed cases with hand-computed results.
        issue(3'd0, 32'hFFFF_FFFD, 32'd5);
        chk("mult_neg", {u_if.HI, u_if.LO}, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        chk("multu", {u_if.HI, u_if.LO}, {32'h0000_0001, 32'hFFFF_FFFE});
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg", {u_if.HI, u_if.LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        issue(3'd4, 32'h1234, 32'd0);
        issue(3'd5, 32'h5678, 32'd0);
        issue(3'd3, 32'd7, 32'd0);
        chk("divu_by_zero", {u_if.HI, u_if.LO}, {32'h0000_1234, 32'h0000_5678});
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_overflow", {u_if.HI, u_if.LO}, {32'h0, 32'h8000_0000});

        // Stall during a mult, plus an ignored second MDStart mid-busy.
        @(posedge clk); #1;
        u_if.DIsMD = 1'b1; u_if.MDStart = 1'b1; u_if.MDOp = 3'd0;
        u_if.A = 32'd6; u_if.B = 32'd7;
        m_hi = 32'd0; m_lo = 32'd42;
        e.hi = m_hi; e.lo = m_lo; e.n = MULT_N;
        sb.push_back(e);
        @(negedge clk);
        chk("stall_launch", 64'(u_if.MDStall), 64'd1);
        @(posedge clk); #1;
        u_if.MDStart = 1'b0;
        for (int i = 0; i < MULT_N; i++) begin
            @(negedge clk);
            chk($sformatf("stall_busy%0d", i), 64'(u_if.MDStall), 64'd1);
            if (i == 1) begin
                u_if.MDStart = 1'b1; u_if.MDOp = 3'd1; u_if.A = 32'd100; u_if.B = 32'd100;
            end else if (i == 2) begin
                u_if.MDStart = 1'b0;
            end
        end
        @(negedge clk); #1;
        chk("stall_idle", 64'(u_if.MDStall), 64'd0);
        chk("ignored_start", {u_if.HI, u_if.LO}, {32'd0, 32'd42});
        chk("stall_sb_empty", 64'(sb.size()), 64'd0);
        sb.delete();

        // Reset on busy cycle 3 of a divide.
        @(posedge clk); #1;
        u_if.MDStart = 1'b1; u_if.MDOp = 3'd2; u_if.A = 32'd100; u_if.B = 32'd3;
        @(posedge clk); #1;
        u_if.MDStart = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(u_if.Busy), 64'd0);
        chk("rst_hilo", {u_if.HI, u_if.LO}, 64'd0);
        chk("rst_stall", 64'(u_if.MDStall), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        u_if.DIsMD = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;

`ifdef MD_MADD_EN
        issue(3'd4, 32'd0, 32'd0);
        issue(3'd5, 32'd10, 32'd0);
        issue(3'd6, 32'd3, 32'd4);
        chk("madd", {u_if.HI, u_if.LO}, {32'd0, 32'd22});
`endif

        // Randomized operations against the model.
        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            issue(rop, ra, rb);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/md_unit_controller.md
Name: md_unit_controller

Overview:
- Sequences the multiply/divide unit that sits beside the ALU in the E stage of the 5-stage pipeline.
- Accepts one MD operation per request from E and computes it over a fixed multi-cycle latency.
- Owns the HI/LO registers and drives the D-stage stall when a decoded MD instruction would collide with a busy unit.
- The main controller supplies MDStart/MDOp; the hazard logic ORs MDStall into the global stall.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- MDStart  input  1  E-stage MD instruction valid this cycle
- MDOp  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 msub
- A  input  32  rs operand, forwarded
- B  input  32  rt operand, forwarded
- DIsMD  input  1  D-stage instruction reads or writes HI/LO (mult/div/mfhi/mflo/mthi/mtlo)
- Busy  output  1  multi-cycle operation in progress
- MDStall  output  1  stall request to the D stage
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. Reset is sampled only on the rising edge of clk.
- Reset values: HI=0, LO=0, Busy=0, counter=0, state=IDLE. Reset overrides everything, including an operation in progress; the pending result is discarded.
- States:
  - IDLE -> BUSY on MDStart with MDOp in 0..3, or 6..7 when enabled.
  - BUSY -> IDLE when the counter reaches 1.
  - mthi/mtlo never leave IDLE.
- Launch edge: A, B and MDOp are latched into internal registers. The counter is loaded with MULT_CYCLES (ops 0,1,6,7) or DIV_CYCLES (ops 2,3). The result is computed into pending registers.
- Busy: high from the cycle after launch for exactly N cycles, where N is the loaded count. The counter decrements each cycle in BUSY.
- Commit: on the edge that returns to IDLE, HI/LO are loaded from the pending result. The new HI/LO are visible from the first IDLE cycle.
- mult: {HI,LO} = signed A × signed B, 64-bit.
- multu: {HI,LO} = unsigned A × unsigned B, 64-bit.
- div: LO = quotient truncated toward zero; HI = remainder, same sign as the dividend.
- divu: same as div, unsigned.
- Divide by zero (B==0 for div/divu): the unit still goes busy for DIV_CYCLES, then HI/LO are left unchanged.
- Signed overflow (div 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- mthi/mtlo: HI or LO = A on the same edge as MDStart, provided state is IDLE. No Busy assertion.
- MDStart while Busy: ignored, with no state change. MDStall is what prevents this from happening.
- MDStall = DIsMD & (Busy | (MDStart & MDOp launches a multi-cycle op)). Purely combinational.
- HI/LO outputs are register outputs; mfhi/mflo read them directly in E.

Optional Feature:
- Macro: MD_MADD_EN.
- When defined:
  - MDOp 6 (madd): {HI,LO} = {HI,LO} + signed A×B.
  - MDOp 7 (msub): {HI,LO} = {HI,LO} − signed A×B.
  - Both use MULT_CYCLES. The accumulator base is the HI/LO value at the launch edge.
- When not defined: MDOp 6/7 are treated as no-ops. No Busy, no HI/LO change, and they are not counted in the MDStall launch term.

Test Plan:
- mult A=0xFFFFFFFD (−3), B=5 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- multu A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu A=7, B=0 after mthi 0x1234/mtlo 0x5678 -> Busy 10 cycles; HI=0x1234 and LO=0x5678 unchanged.
- Launch mult, hold DIsMD=1 -> MDStall=1 on the launch cycle and every Busy cycle, 0 on the first IDLE cycle. A second MDStart during Busy leaves HI/LO equal to the first result.
- Launch div, assert reset on busy cycle 3 -> next cycle Busy=0, HI=0, LO=0, MDStall=0 with DIsMD=1. (With MD_MADD_EN: HI:LO=0:10, madd A=3, B=4 -> LO=22.)
